// File: rtl/iob_reset_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package iob_reset_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4
  } state_e;

  // Width of a counter that must reach the largest of the three intervals.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/iob_sync_2ff.sv
// Generic two-flop synchronizer, async active-low reset, resets to 0.
module iob_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_d, s1_q;
  logic [WIDTH-1:0] s2_d, s2_q;

  // Next values: plain shift through the two metastability stages.
  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/iob_reset_sequencer.sv
// Staged reset sequencer: waits for a stable PLL lock, releases resets one
// stage at a time, and slams them all back on lock loss or software request.
module iob_reset_sequencer
  import iob_reset_seq_pkg::*;
#(
  parameter int N_STAGES    = 3,
  parameter int LOCK_CYCLES = 1024,
  parameter int STAGE_DELAY = 16,
  parameter int HOLD_CYCLES = 32,
  parameter int CNT_W       = 8
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                locked_i,
  input  logic                sw_rst_i,
  output logic [N_STAGES-1:0] rst_o,
  output logic                ready_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    loss_cnt_o
);

  localparam int CW = cnt_width(LOCK_CYCLES, STAGE_DELAY, HOLD_CYCLES);
  localparam int KW = $clog2(N_STAGES) + 1;

  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST     = KW'(N_STAGES - 1);

  logic lk;

  state_e              st_d, st_q;
  logic [CW-1:0]       cnt_d, cnt_q;
  logic [KW-1:0]       k_d, k_q;
  logic [N_STAGES-1:0] rst_d, rst_q;
  logic                ready_d, ready_q;
  logic                busy_d, busy_q;
  logic [CNT_W-1:0]    loss_d, loss_q;

  iob_sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .d_i      (locked_i),
    .q_o      (lk)
  );

  // Next-state and next-output logic; lock loss and sw request override
  // the per-state behaviour, with lock loss taking priority.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    loss_d  = loss_q;

    case (st_q)
      WAIT_LOCK: begin
        rst_d   = '1;
        ready_d = 1'b0;
        cnt_d   = '0;
        if (lk) st_d = STABLE;
      end
      STABLE: begin
        if (!lk) begin
          st_d  = WAIT_LOCK;
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          st_d  = RELEASE;
          cnt_d = '0;
          k_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (cnt_q == STAGE_LAST) begin
          cnt_d = '0;
          // Drop exactly the stage currently pointed at by k.
          for (int i = 0; i < N_STAGES; i++) begin
            if (KW'(i) == k_q) rst_d[i] = 1'b0;
          end
          k_d = k_q + 1'b1;
          if (k_q == K_LAST) begin
            st_d    = RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        rst_d   = '0;
        ready_d = 1'b1;
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          st_d  = RELEASE;
          cnt_d = '0;
          k_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        st_d    = WAIT_LOCK;
        rst_d   = '1;
        ready_d = 1'b0;
        cnt_d   = '0;
        k_d     = '0;
      end
    endcase

    if (st_q == RELEASE || st_q == RUN || st_q == HOLD) begin
      if (!lk) begin
        st_d    = WAIT_LOCK;
        rst_d   = '1;
        ready_d = 1'b0;
        cnt_d   = '0;
        k_d     = '0;
        if (loss_q != '1) loss_d = loss_q + 1'b1;
      end else if (sw_rst_i && st_q != HOLD) begin
        st_d    = HOLD;
        rst_d   = '1;
        ready_d = 1'b0;
        cnt_d   = '0;
        k_d     = '0;
      end
    end

    busy_d = (st_d != RUN);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      st_q    <= WAIT_LOCK;
      cnt_q   <= '0;
      k_q     <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      loss_q  <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      loss_q  <= loss_d;
    end
  end

  assign rst_o      = rst_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign loss_cnt_o = loss_q;

endmodule

// File: tb/tb_iob_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes with their
// cycle stamps; a negedge monitor pops one entry per observed change.
module tb_iob_reset_sequencer;

  localparam int N  = 3;
  localparam int L  = 1024;
  localparam int SD = 16;
  localparam int HC = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          locked = 1'b0;
  logic          sw = 1'b0;
  logic [N-1:0]  rst_o;
  logic          ready_o;
  logic          busy_o;
  logic [CW-1:0] loss_cnt_o;

  iob_reset_sequencer #(
    .N_STAGES(N), .LOCK_CYCLES(L), .STAGE_DELAY(SD), .HOLD_CYCLES(HC), .CNT_W(CW)
  ) dut (
    .clk_i      (clk),
    .arst_n_i   (arst_n),
    .locked_i   (locked),
    .sw_rst_i   (sw),
    .rst_o      (rst_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .loss_cnt_o (loss_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [N-1:0]  rst;
    logic          rdy;
    logic          busy;
    logic [CW-1:0] loss;
  } ev_t;

  ev_t q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push(input int c, input logic [N-1:0] r, input logic rdy,
                      input logic busy, input logic [CW-1:0] l);
    ev_t e;
    e.cyc = c; e.rst = r; e.rdy = rdy; e.busy = busy; e.loss = l;
    q.push_back(e);
  endtask

  // Staged release starting from RELEASE entry at edge r.
  task automatic push_release(input int r, input logic [CW-1:0] l);
    push(r + SD,     3'b110, 1'b0, 1'b1, l);
    push(r + 2 * SD, 3'b100, 1'b0, 1'b1, l);
    push(r + 3 * SD, 3'b000, 1'b1, 1'b0, l);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: any change of the output bundle must match the next queued event.
  logic [N+2+CW-1:0] cur, prev;
  logic              mon_en = 1'b0;
  ev_t               me;
  always @(negedge clk) begin
    cur = {rst_o, ready_o, busy_o, loss_cnt_o};
    if (mon_en && cur !== prev) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_change: got %0h, was %0h (cycle %0d)", cur, prev, cyc);
      end else begin
        me = q.pop_front();
        chk("ev_cycle", cyc,        me.cyc);
        chk("ev_rst",   rst_o,      me.rst);
        chk("ev_ready", ready_o,    me.rdy);
        chk("ev_busy",  busy_o,     me.busy);
        chk("ev_loss",  loss_cnt_o, me.loss);
      end
    end
    prev = cur;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c, d, r, s, a, e;

    // Asynchronous power-on reset.
    #1 arst_n = 1'b0;
    #3;
    chk("por_rst",   rst_o,      3'b111);
    chk("por_ready", ready_o,    1'b0);
    chk("por_busy",  busy_o,     1'b1);
    chk("por_loss",  loss_cnt_o, 2'd0);
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    mon_en = 1'b1;

    // Clean power-up: lock at cycle 10.
    wait_until(10);
    c = cyc; locked = 1'b1;
    r = c + 3 + L;
    push_release(r, 2'd0);
    wait_until(r + 3 * SD + 5);

    // Lock drop in RUN.
    d = cyc; locked = 1'b0;
    push(d + 3, 3'b111, 1'b0, 1'b1, 2'd1);
    wait_until(d + 10);

    // Relock with a 3-cycle glitch around count 500: counter restarts.
    c = cyc; locked = 1'b1;
    wait_until(c + 500);
    d = cyc; locked = 1'b0;
    wait_until(d + 3);
    c = cyc; locked = 1'b1;
    r = c + 3 + L;
    push_release(r, 2'd1);
    wait_until(r + 3 * SD + 5);

    // Software reset pulse in RUN: hold, then staged release.
    s = cyc; sw = 1'b1;
    push(s + 1, 3'b111, 1'b0, 1'b1, 2'd1);
    @(negedge clk); sw = 1'b0;
    r = s + 1 + HC;
    push_release(r, 2'd1);
    wait_until(r + 3 * SD + 5);

    // Lock loss and sw request seen on the same edge: loss wins.
    d = cyc; locked = 1'b0;
    push(d + 3, 3'b111, 1'b0, 1'b1, 2'd2);
    wait_until(d + 2);
    sw = 1'b1;
    @(negedge clk); sw = 1'b0;
    wait_until(d + 10);

    // Third loss, from RUN.
    c = cyc; locked = 1'b1;
    r = c + 3 + L;
    push_release(r, 2'd2);
    wait_until(r + 3 * SD + 5);
    d = cyc; locked = 1'b0;
    push(d + 3, 3'b111, 1'b0, 1'b1, 2'd3);
    wait_until(d + 10);

    // Fourth loss mid-RELEASE: counter saturates at 3.
    c = cyc; locked = 1'b1;
    r = c + 3 + L;
    push(r + SD, 3'b110, 1'b0, 1'b1, 2'd3);
    wait_until(r + SD + 4);
    d = cyc; locked = 1'b0;
    push(d + 3, 3'b111, 1'b0, 1'b1, 2'd3);
    wait_until(d + 10);

    // Asynchronous reset mid-RELEASE.
    c = cyc; locked = 1'b1;
    r = c + 3 + L;
    push(r + SD, 3'b110, 1'b0, 1'b1, 2'd3);
    wait_until(r + SD + 4);
    a = cyc;
    #2 arst_n = 1'b0;
    #1;
    chk("arst_rst",   rst_o,      3'b111);
    chk("arst_ready", ready_o,    1'b0);
    chk("arst_busy",  busy_o,     1'b1);
    chk("arst_loss",  loss_cnt_o, 2'd0);
    push(a + 1, 3'b111, 1'b0, 1'b1, 2'd0);
    wait_until(a + 4);
    e = cyc; arst_n = 1'b1;
    r = e + 3 + L;
    push_release(r, 2'd0);
    wait_until(r + 3 * SD + 5);

    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
